// File: rtl/robertson_mult_ctrl.sv
// Control sequencer for a Robertson two's-complement shift-add multiplier.
// Moore FSM driving the datapath enables, the shift-in mux selects and a start/busy/done handshake.
module robertson_mult_ctrl #(
    parameter int unsigned N = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       q0,
    input  logic       m_msb,
    output logic       ld_m,
    output logic       ld_q,
    output logic       clr_a,
    output logic       f_clr,
    output logic       f_ld,
    output logic       add_en,
    output logic       sub_en,
    output logic       shift_en,
    output logic [2:0] a_sel,
    output logic [2:0] q_sel,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [2:0] SEL_A_F    = 3'd1;
    localparam logic [2:0] SEL_Q_A0   = 3'd0;
    localparam logic [2:0] SEL_IDLE   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TEST,
        S_ADD,
        S_SUB,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The multiplicand sign only feeds the F update inside the datapath.
    logic unused_m_msb;
    assign unused_m_msb = m_msb;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter saturates at N-1 on the final shift so it never wraps mid-operation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_TEST;
            end
            S_TEST: begin
                if (!q0) begin
                    state_d = S_SHIFT;
                end else if (cnt_q == LAST) begin
                    state_d = S_SUB;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_ADD:   state_d = S_SHIFT;
            S_SUB:   state_d = S_SHIFT;
            S_SHIFT: begin
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_TEST;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ld_m     = 1'b0;
        ld_q     = 1'b0;
        clr_a    = 1'b0;
        f_clr    = 1'b0;
        f_ld     = 1'b0;
        add_en   = 1'b0;
        sub_en   = 1'b0;
        shift_en = 1'b0;
        a_sel    = SEL_IDLE;
        q_sel    = SEL_IDLE;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_LOAD: begin
                ld_m  = 1'b1;
                ld_q  = 1'b1;
                clr_a = 1'b1;
                f_clr = 1'b1;
                busy  = 1'b1;
            end
            S_TEST: busy = 1'b1;
            S_ADD: begin
                add_en = 1'b1;
                f_ld   = 1'b1;
                busy   = 1'b1;
            end
            S_SUB: begin
                sub_en = 1'b1;
                busy   = 1'b1;
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                a_sel    = SEL_A_F;
                q_sel    = SEL_Q_A0;
                busy     = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_robertson_mult_ctrl.sv
// Bench for robertson_mult_ctrl: wraps the controller with a register/mux5 datapath and
// checks products, done timing and enable counts through a scoreboard queue.
module tb_robertson_mult_ctrl;

    localparam int N = 8;
    localparam logic [15:0] IDLE_OUTS = 16'h002D;

    logic clk = 1'b0;
    logic reset, start, q0, m_msb;
    logic ld_m, ld_q, clr_a, f_clr, f_ld, add_en, sub_en, shift_en, busy, done;
    logic [2:0] a_sel, q_sel;

    logic [N-1:0] m_in, q_in, m_r, q_r, a_r;
    logic         f_r;
    logic [N:0]   dp_diff;
    logic         a_shin, q_shin;
    logic [15:0]  outs;

    int unsigned edge_cnt = 0;
    int unsigned total = 0;
    int unsigned bad = 0;

    typedef struct {
        int unsigned done_ec;
        logic [15:0] prod;
        int unsigned n_add;
        int unsigned n_sub;
        int unsigned n_shift;
        int unsigned sub_step;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int unsigned mon_add, mon_sub, mon_shift, mon_sub_step;
    int unsigned done_seen = 0;
    int unsigned last_done_ec = 0;
    int unsigned last_gap = 0;
    logic        have_done = 1'b0;

    robertson_mult_ctrl #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .q0       (q0),
        .m_msb    (m_msb),
        .ld_m     (ld_m),
        .ld_q     (ld_q),
        .clr_a    (clr_a),
        .f_clr    (f_clr),
        .f_ld     (f_ld),
        .add_en   (add_en),
        .sub_en   (sub_en),
        .shift_en (shift_en),
        .a_sel    (a_sel),
        .q_sel    (q_sel),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic mux5(input logic [2:0] sel, input logic i0, input logic i1,
                                  input logic i2, input logic i3, input logic i4);
        case (sel)
            3'd0:    return i0;
            3'd1:    return i1;
            3'd2:    return i2;
            3'd3:    return i3;
            3'd4:    return i4;
            default: return 1'b0;
        endcase
    endfunction

    // Datapath: the correction subtract is done at N+1 bits so F carries the product sign.
    assign m_msb   = m_r[N-1];
    assign q0      = q_r[0];
    assign dp_diff = {f_r, a_r} - {m_r[N-1], m_r};
    assign a_shin  = mux5(a_sel, a_r[N-1], f_r, 1'b0, 1'b0, 1'b0);
    assign q_shin  = mux5(q_sel, a_r[0], 1'b0, 1'b0, 1'b0, 1'b0);
    assign outs    = {ld_m, ld_q, clr_a, f_clr, f_ld, add_en, sub_en, shift_en, busy, done,
                      a_sel, q_sel};

    always @(posedge clk) begin
        if (ld_m)  m_r <= m_in;
        if (ld_q)  q_r <= q_in;
        if (clr_a) a_r <= '0;
        if (f_clr) f_r <= 1'b0;
        if (f_ld)  f_r <= f_r | (m_msb & q0);
        if (add_en) a_r <= a_r + m_r;
        if (sub_en) {f_r, a_r} <= dp_diff;
        if (shift_en) begin
            a_r <= {a_shin, a_r[N-1:1]};
            q_r <= {q_shin, q_r[N-1:1]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("excl_enables", 32'($countones({add_en, sub_en, shift_en, ld_q}) <= 1), 1);
            chk("mux_sel", {26'd0, a_sel, q_sel},
                shift_en ? {26'd0, 3'd1, 3'd0} : {26'd0, 3'd5, 3'd5});
            chk("busy_done_excl", {31'd0, busy & done}, 0);
            if (ld_q | add_en | sub_en | shift_en) chk("busy_active", {31'd0, busy}, 1);
            if (done) begin
                done_seen++;
                last_done_ec = edge_cnt;
                have_done = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_cycle", edge_cnt, mon_e.done_ec);
                    chk("product", {16'd0, a_r, q_r}, {16'd0, mon_e.prod});
                    chk("n_add", mon_add, mon_e.n_add);
                    chk("n_sub", mon_sub, mon_e.n_sub);
                    chk("n_shift", mon_shift, mon_e.n_shift);
                    chk("sub_step", mon_sub_step, mon_e.sub_step);
                end
            end
            if (ld_q) begin
                mon_add = 0;
                mon_sub = 0;
                mon_shift = 0;
                mon_sub_step = 0;
                if (have_done) last_gap = edge_cnt - last_done_ec;
            end
            if (add_en) mon_add++;
            if (sub_en) begin
                mon_sub++;
                mon_sub_step = mon_shift + 1;
            end
            if (shift_en) mon_shift++;
        end
    end

    task automatic wait_drain();
        int unsigned i = 0;
        while (sb.size() != 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [7:0] m, input logic [7:0] q, input logic [15:0] prod,
                          input int unsigned cyc, input int unsigned nadd,
                          input int unsigned nsub, input int unsigned sstep,
                          input int unsigned pulse_at);
        int unsigned e;
        @(negedge clk);
        m_in = m;
        q_in = q;
        start = 1'b1;
        @(posedge clk);
        #1;
        e = edge_cnt;
        start = 1'b0;
        sb.push_back('{done_ec: e + cyc - 1, prod: prod, n_add: nadd, n_sub: nsub,
                       n_shift: N, sub_step: sstep});
        if (pulse_at != 0) begin
            repeat (pulse_at) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_drain();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int unsigned e;
        int unsigned done_before;
        reset = 1'b1;
        start = 1'b0;
        m_in = '0;
        q_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {16'd0, outs}, {16'd0, IDLE_OUTS});
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_hold", {16'd0, outs}, {16'd0, IDLE_OUTS});
        end

        // m, q, product, done cycle (2N+k+2), adds, subs, sub step, busy start pulse
        run_op(8'h05, 8'h00, 16'h0000, 18, 0, 0, 0, 0);
        run_op(8'h05, 8'hFD, 16'hFFF1, 25, 6, 1, 8, 0);
        run_op(8'h80, 8'h80, 16'h4000, 19, 0, 1, 8, 0);
        run_op(8'hFB, 8'h03, 16'hFFF1, 20, 2, 0, 0, 5);
        run_op(8'h7F, 8'h7F, 16'h3F01, 25, 7, 0, 0, 0);
        run_op(8'hFF, 8'hFF, 16'h0001, 26, 7, 1, 8, 11);

        // Reset in cycle 7 of an operation aborts it silently.
        done_before = done_seen;
        @(negedge clk);
        m_in = 8'h05;
        q_in = 8'hFD;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_outs", {16'd0, outs}, {16'd0, IDLE_OUTS});
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_no_done", done_seen, done_before);

        // start held for 40 cycles: exactly two back-to-back operations.
        @(negedge clk);
        m_in = 8'hFF;
        q_in = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        e = edge_cnt;
        sb.push_back('{done_ec: e + 25, prod: 16'h0001, n_add: 7, n_sub: 1, n_shift: N,
                       sub_step: 8});
        sb.push_back('{done_ec: e + 27 + 25, prod: 16'h0001, n_add: 7, n_sub: 1, n_shift: N,
                       sub_step: 8});
        repeat (39) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        chk("b2b_load_gap", last_gap, 2);
        done_before = done_seen;
        repeat (30) @(negedge clk);
        chk("b2b_no_third", done_seen, done_before);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
